// File: rtl/inst_mem_loadable.sv
// Instruction memory answering the core's fetch port combinationally,
// writable through a byte-serial program loader with a valid/ready handshake.
module inst_mem_loadable #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           inst,
    input  logic                  ld_start,
    input  logic [DEPTH_LOG2-1:0] ld_base,
    input  logic [DEPTH_LOG2:0]   ld_len,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    output logic                  ld_busy,
    output logic                  ld_done,
    output logic [DEPTH_LOG2:0]   ld_words
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t state;
    state_t next_state;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] ptr;
    logic [DEPTH_LOG2:0]   len;
    logic [1:0]            bcnt;
    logic [23:0]           shift;
    logic                  accept;
    logic                  word_complete;
    logic [DEPTH_LOG2:0]   words_inc;
    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic                  unused_addr_bits;

    assign accept        = ld_valid && ld_ready;
    assign word_complete = accept && (bcnt == 2'd3);
    assign words_inc     = ld_words + 1'b1;
    assign fetch_idx     = addr[DEPTH_LOG2+1:2];

    // Byte-offset and high address bits are deliberately ignored (aliasing)
    assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

    // Fetch is combinational so the core's single-cycle IF stage sees data at once
    always_comb begin
        inst = '0;
        if (ce) begin
            inst = mem[fetch_idx];
        end
    end

    // Loader state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Loader next-state: a load finishes when its final 4th byte is accepted
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    next_state = (ld_len == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (word_complete && (words_inc == len)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Loader handshake outputs decoded from the state
    always_comb begin
        ld_ready = 1'b0;
        ld_busy  = 1'b0;
        ld_done  = 1'b0;
        case (state)
            RECV: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
            end
            DONE:    ld_done = 1'b1;
            default: ;
        endcase
    end

    // Loader datapath: pointer, length, word counter and big-endian byte assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            len      <= '0;
            ld_words <= '0;
            bcnt     <= '0;
            shift    <= '0;
        end else if (state == IDLE) begin
            if (ld_start) begin
                ptr      <= ld_base;
                len      <= ld_len;
                ld_words <= '0;
                bcnt     <= '0;
            end
        end else if (accept) begin
            if (bcnt == 2'd3) begin
                ptr      <= ptr + 1'b1;
                ld_words <= words_inc;
                bcnt     <= '0;
            end else begin
                shift <= {shift[15:0], ld_byte};
                bcnt  <= bcnt + 1'b1;
            end
        end
    end

    // Single write port; contents survive reset so an aborted load keeps finished words
    always_ff @(posedge clk) begin
        if (word_complete && !rst) begin
            mem[ptr] <= {shift, ld_byte};
        end
    end

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Self-checking bench for inst_mem_loadable: randomized loads checked against
// a word-array model, a fetch vector table and hand-written corner sequences.
module tb_inst_mem_loadable;

    localparam int DL2   = 10;
    localparam int DEPTH = 1 << DL2;

    logic           clk = 1'b0;
    logic           rst;
    logic           ce;
    logic [31:0]    addr;
    logic [31:0]    inst;
    logic           ld_start;
    logic [DL2-1:0] ld_base;
    logic [DL2:0]   ld_len;
    logic [7:0]     ld_byte;
    logic           ld_valid;
    logic           ld_ready;
    logic           ld_busy;
    logic           ld_done;
    logic [DL2:0]   ld_words;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp_inst;
    } fetch_vec_t;

    fetch_vec_t fvec [7];

    inst_mem_loadable #(.DEPTH_LOG2(DL2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .addr     (addr),
        .inst     (inst),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_len   (ld_len),
        .ld_byte  (ld_byte),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_busy  (ld_busy),
        .ld_done  (ld_done),
        .ld_words (ld_words)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch_word(input string name, input int idx, input logic [31:0] exp);
        ce   = 1'b1;
        addr = ($urandom << (DL2 + 2)) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
        @(negedge clk);
        check_output(name, inst, exp);
        step();
    endtask

    // Drives one whole load and checks every cycle against the model's timing rules
    task automatic run_load(input int base, input int len, input int gap_pct,
                            input int busy_start_at, input int abort_after,
                            input bit use_fixed, input logic [31:0] fixed_word);
        int          accepted;
        int          total;
        int          cycles;
        int          widx;
        int          last;
        bit          aborted;
        bit          injected;
        bit          v;
        logic [31:0] acc;
        logic [7:0]  b;
        accepted = 0;
        total    = len * 4;
        cycles   = 0;
        aborted  = 1'b0;
        injected = 1'b0;
        acc      = '0;

        ld_base  = base[DL2-1:0];
        ld_len   = len[DL2:0];
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_byte  = 8'hEE;
        @(negedge clk);
        check_output("idle_ready", ld_ready, 0);
        check_output("idle_busy", ld_busy, 0);
        step();
        ld_start = 1'b0;

        if (len == 0) begin
            @(negedge clk);
            check_output("zero_len_done", ld_done, 1);
            check_output("zero_len_ready", ld_ready, 0);
            check_output("zero_len_words", ld_words, 0);
            step();
            ld_valid = 1'b0;
            @(negedge clk);
            check_output("zero_len_done_drop", ld_done, 0);
            check_output("zero_len_busy", ld_busy, 0);
            step();
            return;
        end

        while (accepted < total) begin
            if (accepted == abort_after) begin
                aborted = 1'b1;
                break;
            end
            if (cycles > total * 20 + 50) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL load_timeout: got %0d bytes expected %0d", accepted, total);
                ld_valid = 1'b0;
                return;
            end
            v        = ($urandom_range(0, 99) >= gap_pct);
            b        = use_fixed ? fixed_word[31 - 8 * (accepted % 4) -: 8] : 8'($urandom);
            ld_valid = v;
            ld_byte  = b;
            if (!injected && accepted == busy_start_at) begin
                injected = 1'b1;
                ld_start = 1'b1;
                ld_base  = DL2'($urandom);
                ld_len   = '0;
            end else begin
                ld_start = 1'b0;
            end
            widx = (base + accepted / 4) % DEPTH;
            ce   = 1'b1;
            addr = ($urandom << (DL2 + 2)) | (32'(widx) << 2) | 32'($urandom_range(0, 3));
            @(negedge clk);
            check_output("recv_ready", ld_ready, 1);
            check_output("recv_busy", ld_busy, 1);
            check_output("recv_done", ld_done, 0);
            check_output("recv_words", ld_words, 64'(accepted / 4));
            check_output("recv_fetch", inst, model_mem[widx]);
            @(posedge clk);
            if (v) begin
                acc = {acc[23:0], b};
                accepted++;
                if (accepted % 4 == 0) begin
                    model_mem[widx] = acc;
                end
            end
            #1;
            cycles++;
        end
        ld_start = 1'b0;

        if (aborted) begin
            rst      = 1'b1;
            ld_valid = 1'b1;
            step();
            rst      = 1'b0;
            ld_valid = 1'b0;
            @(negedge clk);
            check_output("abort_ready", ld_ready, 0);
            check_output("abort_busy", ld_busy, 0);
            check_output("abort_done", ld_done, 0);
            check_output("abort_words", ld_words, 0);
            step();
            return;
        end

        last     = (base + len - 1) % DEPTH;
        ld_valid = 1'b1;
        ld_byte  = 8'($urandom);
        ce       = 1'b1;
        addr     = 32'(last) << 2;
        @(negedge clk);
        check_output("done_pulse", ld_done, 1);
        check_output("done_ready", ld_ready, 0);
        check_output("done_busy", ld_busy, 0);
        check_output("done_words", ld_words, 64'(len));
        check_output("done_fetch_new", inst, model_mem[last]);
        step();
        addr = 32'((last + 1) % DEPTH) << 2;
        @(negedge clk);
        check_output("after_done_pulse", ld_done, 0);
        check_output("after_done_ready", ld_ready, 0);
        check_output("after_done_words", ld_words, 64'(len));
        check_output("after_done_no_write", inst, model_mem[(last + 1) % DEPTH]);
        step();
        ld_valid = 1'b0;
    endtask

    // Applies the fixed fetch vector table
    task automatic apply_stimulus();
        for (int i = 0; i < 7; i++) begin
            ce   = fvec[i].ce;
            addr = fvec[i].addr;
            @(negedge clk);
            check_output($sformatf("fetch_vec_%0d", i), inst, fvec[i].exp_inst);
            step();
        end
    endtask

    initial begin
        fvec[0] = '{1'b1, 32'h0000_0000, 32'h3401_0010};
        fvec[1] = '{1'b1, 32'h0000_0002, 32'h3401_0010};
        fvec[2] = '{1'b1, 32'h0000_0003, 32'h3401_0010};
        fvec[3] = '{1'b1, 32'h0000_1000, 32'h3401_0010};
        fvec[4] = '{1'b1, 32'hFFFF_F001, 32'h3401_0010};
        fvec[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
        fvec[6] = '{1'b0, 32'h0000_1002, 32'h0000_0000};

        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        rst      = 1'b1;
        ce       = 1'b0;
        addr     = '0;
        ld_start = 1'b0;
        ld_base  = '0;
        ld_len   = '0;
        ld_byte  = '0;
        ld_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        check_output("reset_ready", ld_ready, 0);
        check_output("reset_busy", ld_busy, 0);
        check_output("reset_done", ld_done, 0);
        check_output("reset_words", ld_words, 0);
        check_output("reset_inst_ce0", inst, 0);
        step();
        rst = 1'b0;
        step();

        $display("[TB] full-depth randomized load");
        run_load(0, DEPTH, 20, -1, -1, 1'b0, 32'h0);

        $display("[TB] single-word load");
        run_load(0, 1, 0, -1, -1, 1'b1, 32'h3401_0010);
        apply_stimulus();

        $display("[TB] gapped multi-word load");
        run_load(1, 3, 40, -1, -1, 1'b0, 32'h0);
        check_fetch_word("gap_word0_kept", 0, 32'h3401_0010);
        for (int i = 1; i <= 3; i++) check_fetch_word("gap_word", i, model_mem[i]);

        $display("[TB] wrap-around load");
        run_load(DEPTH - 1, 2, 0, -1, -1, 1'b0, 32'h0);
        ce   = 1'b1;
        addr = 32'h0000_1000;
        @(negedge clk);
        check_output("wrap_alias_word0", inst, model_mem[0]);
        step();
        check_fetch_word("wrap_top_word", DEPTH - 1, model_mem[DEPTH-1]);

        $display("[TB] zero-length load and busy start");
        run_load(7, 0, 0, -1, -1, 1'b0, 32'h0);
        check_fetch_word("zero_len_no_write", 7, model_mem[7]);
        run_load(10, 3, 30, 5, -1, 1'b0, 32'h0);
        for (int i = 9; i <= 13; i++) check_fetch_word("busy_start_words", i, model_mem[i]);

        $display("[TB] reset mid-load");
        run_load(0, 2, 0, -1, 6, 1'b0, 32'h0);
        check_fetch_word("abort_word0_loaded", 0, model_mem[0]);
        check_fetch_word("abort_word1_kept", 1, model_mem[1]);
        run_load(20, 1, 25, -1, -1, 1'b0, 32'h0);
        check_fetch_word("post_abort_load", 20, model_mem[20]);

        $display("[TB] random fetches");
        for (int i = 0; i < 40; i++) begin
            int idx;
            idx  = $urandom_range(0, DEPTH - 1);
            ce   = 1'($urandom_range(0, 1));
            addr = ($urandom << (DL2 + 2)) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            @(negedge clk);
            check_output("random_fetch", inst, ce ? model_mem[idx] : 32'h0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Instruction-memory responder for the core's fetch port: it answers the core's `rom_ce_o` / `rom_addr_o` requests with `rom_data_i` words. The memory is also writable through a byte-serial program loader with a valid/ready handshake, so a test program can be streamed in without rebuilding the memory image. The block sits beside the CPU core in the SoC top. Its fetch side connects directly to the core's instruction-ROM port, and its loader side connects to a host/UART byte source.

## Interface
- `DEPTH_LOG2`, default 10, log2 of memory depth in 32-bit words (1024 words).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ce`  in  1  fetch enable (from the core's `rom_ce_o`).
- `addr`  in  32  fetch byte address (from the core's `rom_addr_o`).
- `inst`  out  32  fetched instruction word (to the core's `rom_data_i`).
- `ld_start`  in  1  one-cycle pulse that starts a load.
- `ld_base`  in  DEPTH_LOG2  first word index to write; sampled on the accepted `ld_start`.
- `ld_len`  in  DEPTH_LOG2+1  number of words to load; sampled on the accepted `ld_start`.
- `ld_byte`  in  8  loader data byte.
- `ld_valid`  in  1  `ld_byte` is valid.
- `ld_ready`  out  1  block accepts a byte this cycle.
- `ld_busy`  out  1  load in progress.
- `ld_done`  out  1  one-cycle pulse when a load completes.
- `ld_words`  out  DEPTH_LOG2+1  words written by the current or most recent load.

## Operation
- **Fetch path (combinational):**
  - `inst` = 0 when `ce`=0.
  - Otherwise `inst` = `mem[addr[DEPTH_LOG2+1:2]]`.
  - `addr[1:0]` is ignored. Address bits above `DEPTH_LOG2+1` are ignored, so addresses alias modulo the depth.
- **Memory:** `2^DEPTH_LOG2` x 32 bits, one write port owned by the loader. Contents are not cleared by `rst`. The power-up value in simulation is all zeros.
- **FSM states:** IDLE, RECV, DONE.
  - IDLE: `ld_ready`=0, `ld_busy`=0.
    - On `ld_start`=1: latch the base into `ptr`, latch `len`, clear `ld_words`, clear the byte counter `bcnt`.
    - If `ld_len`=0, go to DONE; otherwise go to RECV.
  - RECV: `ld_ready`=1, `ld_busy`=1.
    - A byte is accepted when `ld_valid`&&`ld_ready`.
    - Bytes are assembled big-endian: the first byte of a word goes to bits 31:24 and the fourth to bits 7:0. A shift register holds bytes 1-3.
    - On acceptance of the 4th byte:
      - `mem[ptr]` <= {shift[23:0], `ld_byte`} at that edge.
      - `ptr` <= `ptr`+1, modulo depth (wraps from the top word to 0).
      - `ld_words` <= `ld_words`+1.
      - `bcnt` <= 0.
      - If `ld_words`+1 == `len`, go to DONE.
  - DONE: `ld_done`=1, `ld_busy`=0, `ld_ready`=0. Return to IDLE on the next cycle.
- `ld_start` is ignored outside IDLE.
- `ld_valid` is ignored outside RECV. No byte is consumed in IDLE or DONE.
- **Simultaneous fetch and write:** a fetch to the word being written returns the old value in that cycle and the new value from the next cycle.
- **Reset:**
  - Outputs go to `ld_ready`=0, `ld_busy`=0, `ld_done`=0, `ld_words`=0; the FSM goes to IDLE and `bcnt`=0.
  - `inst` follows `ce`/`addr` combinationally. It is 0 while the core holds `ce` low in reset.
  - Reset during RECV aborts the load. Words already written stay in memory; the partial word is discarded.
- **Width rules:** `ptr` is DEPTH_LOG2 bits and wraps. `ld_words`/`len` are DEPTH_LOG2+1 bits, so a full-depth load is expressible. `ld_len` > depth overwrites from the wrapped `ptr`.

## Timing
- **Fetch:** zero-cycle latency, combinational from `ce`/`addr`. This matches the core's single-cycle IF stage.
- **Start:** `ld_start` sampled at edge N (in IDLE) gives `ld_ready`=1 from cycle N+1.
- **Bytes:** one byte per cycle maximum. `ld_valid` may drop at any time; the byte count holds.
- **Word write:** the word is written at the edge accepting its 4th byte.
- **Completion:** the last byte accepted at edge M gives `ld_done`=1 and `ld_ready`=0 during cycle M+1, then IDLE at M+2. The earliest next `ld_start` is sampled at edge M+2.
- **Zero-length load:** `ld_start` at edge N gives `ld_done` in cycle N+1.

## Test plan
- **Reset values:** after reset, `ld_ready`/`ld_busy`/`ld_done`=0 and `ld_words`=0; `ce`=0 -> `inst`=0.
- **Single-word load:** load base=0, len=1, bytes 34,01,00,10 back-to-back -> `mem[0]`=0x34010010 and `ld_done` one cycle after the 4th byte. Then `ce`=1, `addr`=0x0 -> `inst`=0x34010010; `addr`=0x2 -> same word.
- **Gapped multi-word load:** base=1, len=3, 12 bytes with `ld_valid` gaps -> `ld_words`=3 and `ld_done` pulses once. Fetches at 0x4, 0x8, 0xC return the assembled words; word 0 is unchanged.
- **Wrap-around:** base=1023, len=2 -> writes word 1023 and then word 0. Fetch at 0x1000 aliases to word 0.
- **Zero length and busy start:** `ld_len`=0 -> `ld_done` the next cycle, no write, `ld_words`=0. `ld_start` pulsed during RECV has no effect.
- **Reset mid-load:** reset after 6 bytes of a len=2 load -> word 0 keeps its loaded value, word 1 is unchanged, and the outputs return to reset values.
